// File: rtl/hash_digest_out.sv
// Serializes a captured MD5 (4-word) or SHA-1 (5-word) chaining state onto a
// valid/ready word stream, byte-reversing MD5 words when MD5_BYTE_SWAP is set.
module hash_digest_out #(
    parameter int STATE_DWIDTH  = 32,
    parameter int MD5_BYTE_SWAP = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    msgDgstVld,
    input  logic                    ShaMode,
    input  logic [STATE_DWIDTH-1:0] MuxedStateAComb,
    input  logic [STATE_DWIDTH-1:0] MuxedStateBComb,
    input  logic [STATE_DWIDTH-1:0] MuxedStateCComb,
    input  logic [STATE_DWIDTH-1:0] MuxedStateDComb,
    input  logic [STATE_DWIDTH-1:0] MuxedStateEComb,
    output logic [STATE_DWIDTH-1:0] DgstOut,
    output logic                    DgstOutVld,
    input  logic                    DgstOutRdy,
    output logic                    DgstOutLast,
    output logic                    DgstBusy,
    output logic                    DgstOvfl
);

    localparam int NBYTES = STATE_DWIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic                    sha_q, sha_d;
    logic                    ovfl_q, ovfl_d;
    logic [STATE_DWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;

    logic                    vld;
    logic                    last;
    logic                    xfer;
    logic                    capture;
    logic [STATE_DWIDTH-1:0] word_sel;

    function automatic logic [STATE_DWIDTH-1:0] byte_rev(input logic [STATE_DWIDTH-1:0] w);
        logic [STATE_DWIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) begin
            r[8*i +: 8] = w[STATE_DWIDTH-8-8*i +: 8];
        end
        return r;
    endfunction

    assign vld     = (state_q == SEND);
    assign last    = vld && (idx_q == (sha_q ? 3'd4 : 3'd3));
    assign xfer    = vld && DgstOutRdy;
    // A pulse is only taken when idle or when it lands exactly on the closing transfer.
    assign capture = msgDgstVld && ((state_q == IDLE) || (xfer && last));

    always_comb begin
        word_sel = e_q;
        case (idx_q)
            3'd0:    word_sel = a_q;
            3'd1:    word_sel = b_q;
            3'd2:    word_sel = c_q;
            3'd3:    word_sel = d_q;
            default: word_sel = e_q;
        endcase
    end

    always_comb begin
        DgstOut = '0;
        if (vld) begin
            DgstOut = (!sha_q && (MD5_BYTE_SWAP != 0)) ? byte_rev(word_sel) : word_sel;
        end
    end

    assign DgstOutVld  = vld;
    assign DgstOutLast = last;
    assign DgstBusy    = vld;
    assign DgstOvfl    = ovfl_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sha_d   = sha_q;
        ovfl_d  = ovfl_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        if (capture) begin
            state_d = SEND;
            idx_d   = 3'd0;
            sha_d   = ShaMode;
            a_d     = MuxedStateAComb;
            b_d     = MuxedStateBComb;
            c_d     = MuxedStateCComb;
            d_d     = MuxedStateDComb;
            e_d     = ShaMode ? MuxedStateEComb : '0;
        end else if (xfer) begin
            if (last) begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
        if (msgDgstVld && !capture) begin
            ovfl_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            sha_q   <= 1'b0;
            ovfl_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sha_q   <= sha_d;
            ovfl_q  <= ovfl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
        end
    end

endmodule

// File: tb/tb_hash_digest_out.sv
// Bench for hash_digest_out: table of digests through a word scoreboard, plus
// backpressure, back-to-back, dropped-pulse and mid-stream reset sequences.
module tb_hash_digest_out;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        msgDgstVld;
    logic        ShaMode;
    logic [31:0] sA, sB, sC, sD, sE;
    logic [31:0] DgstOut;
    logic        DgstOutVld;
    logic        DgstOutRdy;
    logic        DgstOutLast;
    logic        DgstBusy;
    logic        DgstOvfl;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } exp_t;

    typedef struct packed {
        logic            sha;
        logic [4:0][31:0] w;
        logic [4:0][31:0] e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];

    hash_digest_out #(
        .STATE_DWIDTH (32),
        .MD5_BYTE_SWAP(1)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .msgDgstVld     (msgDgstVld),
        .ShaMode        (ShaMode),
        .MuxedStateAComb(sA),
        .MuxedStateBComb(sB),
        .MuxedStateCComb(sC),
        .MuxedStateDComb(sD),
        .MuxedStateEComb(sE),
        .DgstOut        (DgstOut),
        .DgstOutVld     (DgstOutVld),
        .DgstOutRdy     (DgstOutRdy),
        .DgstOutLast    (DgstOutLast),
        .DgstBusy       (DgstBusy),
        .DgstOvfl       (DgstOvfl)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard a transfer about to happen on the next edge, then advance one cycle.
    task automatic cyc();
        exp_t ex;
        if (DgstOutVld === 1'b1 && DgstOutRdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h with nothing expected at %0t", DgstOut, $time);
            end else begin
                ex = exp_q.pop_front();
                chk("word", DgstOut, ex.d);
                chk("last", {31'b0, DgstOutLast}, {31'b0, ex.last});
            end
        end else if (DgstOutVld === 1'b0) begin
            chk("zero_when_invalid", DgstOut, 32'h0);
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic pulse(input vec_t v, input bit expect_it);
        int nw;
        nw         = v.sha ? 5 : 4;
        msgDgstVld = 1'b1;
        ShaMode    = v.sha;
        sA = v.w[0]; sB = v.w[1]; sC = v.w[2]; sD = v.w[3]; sE = v.w[4];
        if (expect_it) begin
            for (int k = 0; k < nw; k++) exp_q.push_back('{d: v.e[k], last: (k == nw - 1)});
        end
        cyc();
        msgDgstVld = 1'b0;
        ShaMode    = $urandom_range(0, 1);
        sA = $urandom; sB = $urandom; sC = $urandom; sD = $urandom; sE = $urandom;
    endtask

    task automatic drain(input int nexp, input string nm);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < nexp + 8) begin
            cyc();
            n++;
        end
        chk({nm, "_cycles"}, 32'(n), 32'(nexp));
        chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        vecs[0].sha = 1'b0;
        vecs[0].w   = {32'h0BADF00D, 32'h7E42F8EC, 32'h980980E9, 32'h04B2008F, 32'hD98C1DD4};
        vecs[0].e   = {32'h00000000, 32'hECF8427E, 32'hE9800998, 32'h8F00B204, 32'hD41D8CD9};
        vecs[1].sha = 1'b1;
        vecs[1].w   = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
        vecs[1].e   = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
        vecs[2].sha = 1'b0;
        vecs[2].w   = {32'hDEADBEEF, 32'hFF0000AA, 32'h00000000, 32'h89ABCDEF, 32'h01234567};
        vecs[2].e   = {32'h00000000, 32'hAA0000FF, 32'h00000000, 32'hEFCDAB89, 32'h67452301};
        vecs[3].sha = 1'b1;
        vecs[3].w   = {32'hAABBCCDD, 32'h12345678, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[3].e   = {32'hAABBCCDD, 32'h12345678, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};

        Rst = 1'b1; msgDgstVld = 1'b0; ShaMode = 1'b0; DgstOutRdy = 1'b1;
        sA = '0; sB = '0; sC = '0; sD = '0; sE = '0;
        repeat (2) @(negedge Clk);
        chk("rst_vld", {31'b0, DgstOutVld}, 32'h0);
        chk("rst_last", {31'b0, DgstOutLast}, 32'h0);
        chk("rst_busy", {31'b0, DgstBusy}, 32'h0);
        chk("rst_ovfl", {31'b0, DgstOvfl}, 32'h0);
        chk("rst_out", DgstOut, 32'h0);
        Rst = 1'b0;
        cyc();

        for (int i = 0; i < 4; i++) begin
            DgstOutRdy = 1'b1;
            pulse(vecs[i], 1'b1);
            chk("first_vld", {31'b0, DgstOutVld}, 32'h1);
            chk("first_word", DgstOut, vecs[i].e[0]);
            drain(vecs[i].sha ? 5 : 4, "table");
            chk("vld_after_last", {31'b0, DgstOutVld}, 32'h0);
            chk("busy_after_last", {31'b0, DgstBusy}, 32'h0);
            chk("ovfl_clean", {31'b0, DgstOvfl}, 32'h0);
            cyc();
        end

        // Backpressure on word B
        pulse(vecs[0], 1'b1);
        cyc();
        DgstOutRdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_word", DgstOut, vecs[0].e[1]);
            chk("bp_hold_vld", {31'b0, DgstOutVld}, 32'h1);
            chk("bp_hold_last", {31'b0, DgstOutLast}, 32'h0);
            cyc();
        end
        DgstOutRdy = 1'b1;
        chk("bp_release_word", DgstOut, vecs[0].e[1]);
        drain(3, "bp");
        cyc();

        // New pulse on the last-word transfer: no bubble, no overflow
        pulse(vecs[2], 1'b1);
        repeat (3) cyc();
        chk("b2b_last_before", {31'b0, DgstOutLast}, 32'h1);
        pulse(vecs[1], 1'b1);
        chk("b2b_vld", {31'b0, DgstOutVld}, 32'h1);
        chk("b2b_word_a", DgstOut, vecs[1].e[0]);
        chk("b2b_ovfl", {31'b0, DgstOvfl}, 32'h0);
        drain(5, "b2b");

        // Pulse during word B is dropped and flags overflow
        pulse(vecs[3], 1'b1);
        cyc();
        pulse(vecs[0], 1'b0);
        chk("drop_ovfl", {31'b0, DgstOvfl}, 32'h1);
        chk("drop_inflight_c", DgstOut, vecs[3].e[2]);
        drain(3, "drop");
        chk("drop_vld_after", {31'b0, DgstOutVld}, 32'h0);
        repeat (2) cyc();
        chk("ovfl_sticky", {31'b0, DgstOvfl}, 32'h1);

        // Reset while word C is presented
        pulse(vecs[0], 1'b1);
        cyc();
        cyc();
        chk("rst_mid_word_c", DgstOut, vecs[0].e[2]);
        DgstOutRdy = 1'b0;
        Rst        = 1'b1;
        msgDgstVld = 1'b1;
        cyc();
        chk("rstmid_vld", {31'b0, DgstOutVld}, 32'h0);
        chk("rstmid_busy", {31'b0, DgstBusy}, 32'h0);
        chk("rstmid_ovfl", {31'b0, DgstOvfl}, 32'h0);
        chk("rstmid_last", {31'b0, DgstOutLast}, 32'h0);
        exp_q.delete();
        Rst        = 1'b0;
        msgDgstVld = 1'b0;
        DgstOutRdy = 1'b1;
        cyc();
        chk("rstmid_ignored_pulse", {31'b0, DgstOutVld}, 32'h0);
        pulse(vecs[0], 1'b1);
        chk("rstmid_fresh_a", DgstOut, vecs[0].e[0]);
        drain(4, "fresh");
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_digest_out.md
HASH_DIGEST_OUT -- requirements
Module: hash_digest_out

Interface
REQ-001 Parameter STATE_DWIDTH, default 32, width of each chaining-state word and of the output word.
REQ-002 Parameter MD5_BYTE_SWAP, default 1, 1 = byte-reverse each word on output in MD5 mode.
REQ-003 Clk  input  1  single clock for all logic, rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 msgDgstVld  input  1  one-cycle pulse: final digest present on the MuxedState*Comb inputs this cycle.
REQ-006 ShaMode  input  1  sampled with msgDgstVld; 0 = MD5 (4 words), 1 = SHA-1 (5 words).
REQ-007 MuxedStateAComb..MuxedStateEComb  input  STATE_DWIDTH each  final chaining state A..E from the mux stage.
REQ-008 DgstOut  output  STATE_DWIDTH  serialized digest word.
REQ-009 DgstOutVld  output  1  DgstOut holds a valid word.
REQ-010 DgstOutRdy  input  1  consumer accepts the word; transfer = DgstOutVld & DgstOutRdy.
REQ-011 DgstOutLast  output  1  high with the final word of a digest.
REQ-012 DgstBusy  output  1  a captured digest is still being sent.
REQ-013 DgstOvfl  output  1  sticky: a digest pulse was dropped.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 IDLE + msgDgstVld SHALL capture A..E and ShaMode into holding registers, clear the word index to 0, and go to SEND.
REQ-016 DgstOutVld SHALL assert on the cycle after capture (latency 1), presenting word A.
REQ-017 Words SHALL be sent in order A, B, C, D, then E (SHA mode only); the index advances only on a transfer.
REQ-018 While DgstOutVld=1 and DgstOutRdy=0, DgstOut, DgstOutLast and the index SHALL hold stable.
REQ-019 DgstOutLast SHALL be 1 exactly when index = 3 (MD5) or index = 4 (SHA), and DgstOutVld=1.
REQ-020 A transfer with DgstOutLast=1 SHALL return the FSM to IDLE, with DgstOutVld=0 next cycle, except as in REQ-021.
REQ-021 If msgDgstVld coincides with the last-word transfer, the new digest SHALL be captured and the FSM SHALL remain in SEND, presenting the new word A next cycle with no bubble.
REQ-022 msgDgstVld in SEND, other than the REQ-021 case, SHALL be ignored; the digest in flight SHALL be unaffected, and DgstOvfl SHALL set next cycle.
REQ-023 In MD5 mode with MD5_BYTE_SWAP=1, each output word SHALL be byte-reversed ([7:0] to [31:24] and so on); SHA mode words SHALL be output unmodified.
REQ-024 DgstOut SHALL be 0 whenever DgstOutVld=0.
REQ-025 DgstBusy SHALL equal (state == SEND).
REQ-026 MuxedStateEComb SHALL be ignored when the captured ShaMode=0.

Reset
REQ-027 Rst=1 at a clock edge SHALL force IDLE, index 0, DgstOutVld=0, DgstOutLast=0, DgstBusy=0, DgstOut=0, DgstOvfl=0, and holding registers to 0.
REQ-028 Rst mid-SEND SHALL abandon the digest with no further words; msgDgstVld during Rst SHALL be ignored.
REQ-029 DgstOvfl SHALL clear only by Rst.

Verification
REQ-030 MD5 "" digest: pulse with A=D98C1DD4, B=04B2008F, C=980980E9, D=7E42F8EC, ShaMode=0, Rdy=1 -> words D41D8CD9, 8F00B204, E9800998, ECF8427E on cycles 1-4; Last on cycle 4; Vld=0 on cycle 5.
REQ-031 SHA-1 digest: pulse with A..E = 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0, ShaMode=1 -> the same 5 words unswapped; Last on word 5.
REQ-032 Backpressure: Rdy low for 3 cycles on word B -> B held stable for 4 cycles with Vld=1; no word lost or duplicated.
REQ-033 Back-to-back: second pulse on the same cycle as the last-word transfer -> second digest word A on the next cycle, DgstOvfl=0; a pulse during word B -> dropped, DgstOvfl=1.
REQ-034 Reset mid-stream: Rst asserted during word C -> next cycle Vld=0, Busy=0, Ovfl=0; a fresh pulse then sends from word A.
